// File: rtl/scara_kin_pkg.sv
// Shared types and constants for the SCARA kinematics blocks.
package scara_kin_pkg;

    localparam int unsigned ANGLE_W  = 13;
    localparam int unsigned POS_W    = 15;
    localparam int unsigned LEN_W    = 14;
    localparam int unsigned Z_W      = ANGLE_W + 3;
    localparam int unsigned K_W      = 16;
    localparam int unsigned CORDIC_K = 39797;
    localparam int unsigned ATAN_N   = 16;

    localparam int POS_MAX = (2 ** (POS_W - 1)) - 1;
    localparam int POS_MIN = -(2 ** (POS_W - 1));

    // atan(2^-i) in 16-bit binary-angle units (65536 = one revolution)
    localparam logic [Z_W-1:0] atan_tab [0:ATAN_N-1] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297,
        16'd651,  16'd326,  16'd163,  16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,
        16'd3,    16'd1,    16'd1,    16'd0
    };

    typedef enum logic [2:0] {
        FK_IDLE,
        FK_LOAD1,
        FK_ROT1,
        FK_LOAD2,
        FK_ROT2,
        FK_SUM,
        FK_DONE
    } fk_state_t;

    // Clamp a signed integer position into the POS_W output range
    function automatic logic [POS_W-1:0] sat_pos(input int v);
        if (v > POS_MAX) begin
            return POS_W'(POS_MAX);
        end else if (v < POS_MIN) begin
            return POS_W'(POS_MIN);
        end
        return POS_W'(v);
    endfunction

endpackage

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock after start.
// done is high during the cycle in which the final iteration executes, so the
// caller can leave its rotate state on that edge and find x/y final next cycle.
module cordic_rotator
    import scara_kin_pkg::*;
#(
    parameter int unsigned ITER = 16,
    parameter int unsigned DW   = 22
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] x0,
    input  logic [DW-1:0] y0,
    input  logic [Z_W-1:0] z0,
    output logic [DW-1:0] x,
    output logic [DW-1:0] y,
    output logic          done
);

    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    logic signed [DW-1:0]  x_q, x_d, y_q, y_d;
    logic signed [Z_W-1:0] z_q, z_d;
    logic [CNT_W-1:0]      iter_q, iter_d;
    logic                  run_q, run_d;
    logic                  done_q, done_d;
    logic signed [DW-1:0]  x_sh_c, y_sh_c;
    logic signed [Z_W-1:0] atan_c;

    // Load on start, otherwise rotate toward z = 0 while running
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        iter_d = iter_q;
        run_d  = run_q;
        done_d = 1'b0;
        x_sh_c = x_q >>> iter_q;
        y_sh_c = y_q >>> iter_q;
        atan_c = $signed(atan_tab[4'(iter_q)]);
        if (start) begin
            x_d    = $signed(x0);
            y_d    = $signed(y0);
            z_d    = $signed(z0);
            iter_d = '0;
            run_d  = 1'b1;
            done_d = (ITER == 1);
        end else if (run_q) begin
            if (!z_q[Z_W-1]) begin
                x_d = x_q - y_sh_c;
                y_d = y_q + x_sh_c;
                z_d = z_q - atan_c;
            end else begin
                x_d = x_q + y_sh_c;
                y_d = y_q - x_sh_c;
                z_d = z_q + atan_c;
            end
            if (iter_q == CNT_W'(ITER - 1)) begin
                run_d = 1'b0;
            end else begin
                iter_d = iter_q + CNT_W'(1);
            end
            done_d = (ITER > 1) && (iter_q == CNT_W'(ITER - 2));
        end
    end

    // Rotator state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            iter_q <= iter_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign done = done_q;

endmodule

// File: rtl/forward_kinematics.sv
// Two-link SCARA forward kinematics on one time-shared CORDIC rotator.
// Optional macro FK_ROUND_EN: round-half-up on the final fractional drop
// (default build truncates toward -inf).
module forward_kinematics
    import scara_kin_pkg::*;
#(
    parameter int unsigned ITER = 16,
    parameter int unsigned FRAC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [ANGLE_W-1:0] th1,
    input  logic [ANGLE_W-1:0] th2,
    input  logic [LEN_W-1:0]   l1,
    input  logic [LEN_W-1:0]   l2,
    output logic               busy,
    output logic               dataReady,
    output logic [POS_W-1:0]   xPos,
    output logic [POS_W-1:0]   yPos
);

    localparam int unsigned DW     = 18 + FRAC;
    localparam int unsigned PROD_W = LEN_W + K_W;
    localparam logic signed [ANGLE_W:0] QTR  = (ANGLE_W + 1)'(2048);
    localparam logic signed [ANGLE_W:0] NQTR = -QTR;
    localparam logic signed [ANGLE_W:0] HALF = (ANGLE_W + 1)'(4096);
`ifdef FK_ROUND_EN
    localparam logic signed [DW-1:0] RND_HALF = DW'(2 ** (FRAC - 1));
`endif

    fk_state_t            state_q, state_d;
    logic [ANGLE_W-1:0]   th1_q, th1_d, th2_q, th2_d;
    logic [LEN_W-1:0]     l1_q, l1_d, l2_q, l2_d;
    logic signed [DW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic                 busy_q, busy_d;
    logic                 ready_q, ready_d;
    logic [POS_W-1:0]     x_pos_q, x_pos_d, y_pos_q, y_pos_d;

    logic [ANGLE_W-1:0]       ang_c;
    logic signed [ANGLE_W:0]  ang_ext_c;
    logic [LEN_W-1:0]         len_c;
    logic [PROD_W-1:0]        prod_c;
    logic signed [DW-1:0]     mag_c;
    logic                     flip_c;
    logic [ANGLE_W-1:0]       z_pre_c;
    logic signed [DW-1:0]     x0_c;
    logic [Z_W-1:0]           z0_c;
    logic                     start_c;
    logic signed [DW-1:0]     rot_x, rot_y;
    logic                     rot_done;
    logic signed [DW-1:0]     sum_x_c, sum_y_c, rnd_x_c, rnd_y_c, int_x_c, int_y_c;

    // Rotator setup for the current link: angle select, K scaling, quadrant fold
    always_comb begin
        ang_c = th1_q;
        len_c = l1_q;
        if (state_q == FK_LOAD2) begin
            ang_c = ANGLE_W'(th1_q + th2_q);
            len_c = l2_q;
        end
        ang_ext_c = {ang_c[ANGLE_W-1], ang_c};
        prod_c    = PROD_W'(len_c) * PROD_W'(K_W'(CORDIC_K));
        mag_c     = $signed(DW'(prod_c >> (K_W - FRAC)));
        flip_c    = 1'b0;
        z_pre_c   = ang_c;
        if (ang_ext_c > QTR) begin
            flip_c  = 1'b1;
            z_pre_c = ANGLE_W'(ang_ext_c - HALF);
        end else if (ang_ext_c < NQTR) begin
            flip_c  = 1'b1;
            z_pre_c = ANGLE_W'(ang_ext_c + HALF);
        end
        x0_c    = flip_c ? -mag_c : mag_c;
        z0_c    = {z_pre_c, 3'b000};
        start_c = (state_q == FK_LOAD1) || (state_q == FK_LOAD2);
    end

    cordic_rotator #(
        .ITER (ITER),
        .DW   (DW)
    ) u_rot (
        .clk   (clk),
        .reset (reset),
        .start (start_c),
        .x0    (x0_c),
        .y0    (DW'(0)),
        .z0    (z0_c),
        .x     (rot_x),
        .y     (rot_y),
        .done  (rot_done)
    );

    // Second-link sum and fixed-point to integer conversion
    always_comb begin
        sum_x_c = acc_x_q + rot_x;
        sum_y_c = acc_y_q + rot_y;
`ifdef FK_ROUND_EN
        rnd_x_c = sum_x_c + RND_HALF;
        rnd_y_c = sum_y_c + RND_HALF;
`else
        rnd_x_c = sum_x_c;
        rnd_y_c = sum_y_c;
`endif
        int_x_c = rnd_x_c >>> FRAC;
        int_y_c = rnd_y_c >>> FRAC;
    end

    // Sequencing FSM: capture, two rotations, accumulate, publish
    always_comb begin
        state_d = state_q;
        th1_d   = th1_q;
        th2_d   = th2_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        acc_x_d = acc_x_q;
        acc_y_d = acc_y_q;
        ready_d = 1'b0;
        x_pos_d = x_pos_q;
        y_pos_d = y_pos_q;
        case (state_q)
            FK_IDLE: begin
                if (enable) begin
                    th1_d   = th1;
                    th2_d   = th2;
                    l1_d    = l1;
                    l2_d    = l2;
                    state_d = FK_LOAD1;
                end
            end
            FK_LOAD1: state_d = FK_ROT1;
            FK_ROT1: begin
                if (rot_done) begin
                    state_d = FK_LOAD2;
                end
            end
            FK_LOAD2: begin
                acc_x_d = rot_x;
                acc_y_d = rot_y;
                state_d = FK_ROT2;
            end
            FK_ROT2: begin
                if (rot_done) begin
                    state_d = FK_SUM;
                end
            end
            FK_SUM: begin
                acc_x_d = sum_x_c;
                acc_y_d = sum_y_c;
                x_pos_d = sat_pos(32'(int_x_c));
                y_pos_d = sat_pos(32'(int_y_c));
                ready_d = 1'b1;
                state_d = FK_DONE;
            end
            FK_DONE: state_d = FK_IDLE;
            default: state_d = FK_IDLE;
        endcase
        busy_d = (state_d != FK_IDLE);
    end

    // Control and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FK_IDLE;
            th1_q   <= '0;
            th2_q   <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
            acc_x_q <= '0;
            acc_y_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            x_pos_q <= '0;
            y_pos_q <= '0;
        end else begin
            state_q <= state_d;
            th1_q   <= th1_d;
            th2_q   <= th2_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            acc_x_q <= acc_x_d;
            acc_y_q <= acc_y_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            x_pos_q <= x_pos_d;
            y_pos_q <= y_pos_d;
        end
    end

    assign busy      = busy_q;
    assign dataReady = ready_q;
    assign xPos      = x_pos_q;
    assign yPos      = y_pos_q;

endmodule
